tx_serial_uart_param: RTL and testbench
=======================================

# tx_serial_uart_param

Parametrised asynchronous serial transmitter. It takes one parallel word per valid/ready handshake and emits a complete UART frame on `saida_serial`: start bit, data LSB-first, optional parity, and 1 or 2 stop bits. Each bit lasts a programmable number of clock cycles. It is the general-purpose TX used by every serial link in the design, and replaces fixed-format, externally-sequenced transmitters: baud timing and sequencing are internal.

## Interface
- `N_DADOS`, default 8: data bits per frame, legal range 5..9.
- `PARIDADE`, default 1: parity mode. 0 = none, 1 = odd, 2 = even.
- `N_STOP`, default 1: stop bits, 1 or 2.
- `DIV_BAUD`, default 434: clock cycles per bit, must be ≥ 2 (434 gives 115200 Bd at 50 MHz).
- `clock`, in, 1: single clock. All logic is rising-edge.
- `reset`, in, 1: synchronous, active-low reset.
- `partida`, in, 1: request/valid. A frame is accepted when `partida && pronto` at a rising edge.
- `dados`, in, N_DADOS: word to send. Sampled only at the acceptance edge.
- `pronto`, out, 1: ready. High only in REPOUSO.
- `saida_serial`, out, 1: serial line. Registered; idles high.
- `fim`, out, 1: one-cycle pulse after the last stop bit completes.
- `db_estado`, out, 2: current FSM state code, for debug.
- `db_bit`, out, $clog2(L+1): index of the bit currently on the line, for debug.

## Operation
- Frame length: L = 1 + N_DADOS + (PARIDADE≠0) + N_STOP.
- Frame layout: start `0`, then `dados[0]`…`dados[N_DADOS-1]`, then parity if enabled, then N_STOP `1`s.
- Parity bit: odd mode = `~^dados`, even mode = `^dados`. It is computed from the word latched at acceptance.
- FSM has three states:
  - REPOUSO: `pronto`=1, line=1. Goes to TRANSMITE on `partida`.
  - TRANSMITE: `pronto`=0. Sends the L bits. Goes to FINAL when the last stop bit's period expires.
  - FINAL: exactly one cycle, `fim`=1, `pronto`=0, line=1. Goes to REPOUSO.
- State codes: REPOUSO=0, TRANSMITE=1, FINAL=2.
- At acceptance the full frame is loaded into a shift register. A baud counter runs 0..DIV_BAUD-1.
- At counter wrap: shift one bit and increment `db_bit`. Shift-in value is `1`.
- `partida` asserted while `pronto`=0 is ignored, not queued.
- Changes on `dados` after acceptance have no effect on the frame in flight.
- Active reset (`reset`=0 at a rising edge), whether idle or mid-frame, takes effect at that edge:
  - FSM goes to REPOUSO.
  - `saida_serial`=1, `pronto`=1, `fim`=0.
  - Counters and `db_bit` clear to 0, `db_estado`=0.
  - Any frame in progress is aborted silently, with no `fim`.

## Timing
- Acceptance edge k: `saida_serial` goes to 0 (start bit) at edge k+1.
- Bit i occupies edges k+1+i·DIV_BAUD through k+(i+1)·DIV_BAUD.
- Edge k+1+L·DIV_BAUD: FINAL state. `fim`=1, line=1.
- Edge k+2+L·DIV_BAUD: back in REPOUSO, `pronto`=1.
- Back-to-back operation with `partida` held high:
  - Next acceptance happens at edge k+2+L·DIV_BAUD.
  - The next start bit appears one edge later.
  - Stop-to-start gap is exactly 2 idle-high cycles: the FINAL cycle and the REPOUSO acceptance cycle.
- `fim` and `pronto` are never high in the same cycle.
- Widths:
  - Baud counter: $clog2(DIV_BAUD) bits.
  - Bit counter: $clog2(L+1) bits.
  - No overflow is possible within legal parameters.

## Structure
- Package `tx_serial_pkg` holds:
  - state encoding constants (REPOUSO=0, TRANSMITE=1, FINAL=2);
  - parity-mode constants (PAR_NENHUMA=0, PAR_IMPAR=1, PAR_PAR=2);
  - a frame-length function of (N_DADOS, PARIDADE, N_STOP).
- Reuse existing `deslocador_n` with N=L for the frame shift register: `carrega` on acceptance, `desloca` on baud wrap, `entrada_serial`=1.
- Baud counter and bit counter are inline in the FSM module.
- Parameter legality is checked at elaboration with an error on violation.

## Test plan
- 8O1, DIV_BAUD=4, `dados`=0x55 → line: start `0`, data `1,0,1,0,1,0,1,0`, parity `1`, stop `1`. L=11. `fim` at k+45, `pronto` at k+46.
- 7N2 (N_DADOS=7, PARIDADE=0, N_STOP=2), DIV_BAUD=4, `dados`=0x41 → bits `0,1,0,0,0,0,0,1,1,1`. L=10. `fim` at k+41.
- 8E1, `dados`=0x07 → parity bit `1`. `dados`=0x03 → parity bit `0`.
- Accept 0xA5, then pulse `partida` with `dados`=0x3C mid-frame → only the 0xA5 frame is sent, one `fim`, `dados` changes ignored.
- Reset low during data bit 3 → at the next edge line=1, `pronto`=1, `db_estado`=0, `db_bit`=0. No `fim` for the aborted frame. The next request then sends a full clean frame.
- `partida` held high, 0x55 then 0xAA → two consecutive frames, exactly 2 high cycles between the stop bit and the second start bit, two `fim` pulses.

Source files
------------

// File: rtl/tx_serial_pkg.sv
// rtl/tx_serial_pkg.sv - shared state codes, parity modes and frame-length helper for the UART TX
package tx_serial_pkg;

    typedef enum logic [1:0] {
        REPOUSO   = 2'd0,
        TRANSMITE = 2'd1,
        FINAL     = 2'd2
    } estado_t;

    localparam int PAR_NENHUMA = 0;
    localparam int PAR_IMPAR   = 1;
    localparam int PAR_PAR     = 2;

    function automatic int comprimento_quadro(input int n_dados, input int paridade, input int n_stop);
        return 1 + n_dados + ((paridade != PAR_NENHUMA) ? 1 : 0) + n_stop;
    endfunction

endpackage

// File: rtl/tx_serial_uart_param_if.sv
// rtl/tx_serial_uart_param_if.sv - request/ready handshake and serial line of the UART TX
interface tx_serial_uart_param_if #(
    parameter int N_DADOS = 8
);
    logic               partida;
    logic [N_DADOS-1:0] dados;
    logic               pronto;
    logic               saida_serial;
    logic               fim;

    modport master (output partida, dados, input pronto, saida_serial, fim);
    modport slave  (input partida, dados, output pronto, saida_serial, fim);
endinterface

// File: rtl/deslocador_n.sv
// rtl/deslocador_n.sv - N-bit load/shift-right register; bit 0 is the serial output
module deslocador_n #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carrega,
    input  logic         desloca,
    input  logic         entrada_serial,
    input  logic [N-1:0] dados,
    output logic         saida_serial
);
    logic [N-1:0] reg_q, reg_d;

    always_comb begin
        reg_d = reg_q;
        if (carrega) begin
            reg_d = dados;
        end else if (desloca) begin
            reg_d = {entrada_serial, reg_q[N-1:1]};
        end
    end

    // All-ones at reset so the line idles high straight out of reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            reg_q <= '1;
        end else begin
            reg_q <= reg_d;
        end
    end

    assign saida_serial = reg_q[0];
endmodule

// File: rtl/tx_serial_uart_param.sv
// rtl/tx_serial_uart_param.sv - parametrised UART transmitter: handshake FSM, baud and bit counters
module tx_serial_uart_param
    import tx_serial_pkg::*;
#(
    parameter int N_DADOS  = 8,
    parameter int PARIDADE = 1,
    parameter int N_STOP   = 1,
    parameter int DIV_BAUD = 434,
    localparam int L       = comprimento_quadro(N_DADOS, PARIDADE, N_STOP),
    localparam int W_BIT   = $clog2(L + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    tx_serial_uart_param_if.slave bus,
    output logic [1:0]            db_estado,
    output logic [W_BIT-1:0]      db_bit
);
    localparam int                W_BAUD   = $clog2(DIV_BAUD);
    localparam logic [W_BAUD-1:0] BAUD_FIM = W_BAUD'(DIV_BAUD - 1);
    localparam logic [W_BIT-1:0]  BIT_ULT  = W_BIT'(L - 1);

    if (N_DADOS < 5 || N_DADOS > 9 || PARIDADE < 0 || PARIDADE > 2 ||
        N_STOP < 1 || N_STOP > 2 || DIV_BAUD < 2) begin : g_param_ilegal
        $error("tx_serial_uart_param: illegal parameter combination");
    end

    estado_t           estado_q, estado_d;
    logic [W_BAUD-1:0] baud_q, baud_d;
    logic [W_BIT-1:0]  bit_q, bit_d;
    logic              carrega, desloca;
    logic              paridade_bit;
    logic [L-1:0]      quadro;

    // Whole frame, LSB = start bit; positions past the parity stay 1 as stop bits
    always_comb begin
        paridade_bit = (PARIDADE == PAR_IMPAR) ? ~^bus.dados : ^bus.dados;
        quadro               = '1;
        quadro[0]            = 1'b0;
        quadro[N_DADOS:1]    = bus.dados;
        if (PARIDADE != PAR_NENHUMA) begin
            quadro[N_DADOS+1] = paridade_bit;
        end
    end

    always_comb begin
        estado_d = estado_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        carrega  = 1'b0;
        desloca  = 1'b0;
        case (estado_q)
            REPOUSO: begin
                baud_d = '0;
                bit_d  = '0;
                if (bus.partida) begin
                    carrega  = 1'b1;
                    estado_d = TRANSMITE;
                end
            end
            TRANSMITE: begin
                if (baud_q == BAUD_FIM) begin
                    baud_d  = '0;
                    desloca = 1'b1;
                    if (bit_q == BIT_ULT) begin
                        bit_d    = '0;
                        estado_d = FINAL;
                    end else begin
                        bit_d = bit_q + W_BIT'(1);
                    end
                end else begin
                    baud_d = baud_q + W_BAUD'(1);
                end
            end
            FINAL: begin
                estado_d = REPOUSO;
            end
            default: begin
                estado_d = REPOUSO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= REPOUSO;
            baud_q   <= '0;
            bit_q    <= '0;
        end else begin
            estado_q <= estado_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
        end
    end

    // The shift register output is the registered line; ones shifted in leave it idle-high
    deslocador_n #(.N(L)) u_quadro (
        .clock          (clock),
        .reset          (reset),
        .carrega        (carrega),
        .desloca        (desloca),
        .entrada_serial (1'b1),
        .dados          (quadro),
        .saida_serial   (bus.saida_serial)
    );

    assign bus.pronto = (estado_q == REPOUSO);
    assign bus.fim    = (estado_q == FINAL);
    assign db_estado  = estado_q;
    assign db_bit     = bit_q;
endmodule

// File: tb/tb_tx_serial_uart_param.sv
// tb/tb_tx_serial_uart_param.sv - bench for the UART TX in 8O1, 7N2 and 8E1 configurations
module tb_tx_serial_uart_param;
    localparam int D = 4;

    typedef struct { int dut; logic [7:0] dados; logic [15:0] bits; int len; } vetor_t;
    typedef struct { int dut; logic [15:0] bits; int len; } quadro_t;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [2:0]  partida = '0;
    logic [7:0]  dados   = '0;
    logic [2:0]  linha, pronto, fim;
    logic [5:0]  est_all;
    logic [11:0] bit_all;

    int      n_cmp = 0;
    int      n_err = 0;
    int      n_fim [3] = '{0, 0, 0};
    int      cfg_n [3] = '{8, 7, 8};
    int      cfg_p [3] = '{1, 0, 2};
    int      cfg_s [3] = '{1, 2, 1};
    quadro_t fila [$];
    vetor_t  tab [8];

    always #5 clk = ~clk;

    tx_serial_uart_param_if #(.N_DADOS(8)) if_o ();
    tx_serial_uart_param_if #(.N_DADOS(7)) if_n ();
    tx_serial_uart_param_if #(.N_DADOS(8)) if_e ();

    assign if_o.partida = partida[0];
    assign if_n.partida = partida[1];
    assign if_e.partida = partida[2];
    assign if_o.dados   = dados;
    assign if_n.dados   = dados[6:0];
    assign if_e.dados   = dados;
    assign linha  = {if_e.saida_serial, if_n.saida_serial, if_o.saida_serial};
    assign pronto = {if_e.pronto, if_n.pronto, if_o.pronto};
    assign fim    = {if_e.fim, if_n.fim, if_o.fim};

    tx_serial_uart_param #(.N_DADOS(8), .PARIDADE(1), .N_STOP(1), .DIV_BAUD(D)) u_o (
        .clock(clk), .reset(rst_n), .bus(if_o), .db_estado(est_all[1:0]), .db_bit(bit_all[3:0]));
    tx_serial_uart_param #(.N_DADOS(7), .PARIDADE(0), .N_STOP(2), .DIV_BAUD(D)) u_n (
        .clock(clk), .reset(rst_n), .bus(if_n), .db_estado(est_all[3:2]), .db_bit(bit_all[7:4]));
    tx_serial_uart_param #(.N_DADOS(8), .PARIDADE(2), .N_STOP(1), .DIV_BAUD(D)) u_e (
        .clock(clk), .reset(rst_n), .bus(if_e), .db_estado(est_all[5:4]), .db_bit(bit_all[11:8]));

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (fim[i] === 1'b1) n_fim[i] <= n_fim[i] + 1;
        end
    end

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esp);
        n_cmp++;
        if (atual !== esp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nome, atual, esp);
        end
    endtask

    function automatic logic [15:0] modelo(input int d, input logic [7:0] v, output int len);
        logic [15:0] b;
        int uns, pos;
        b = '1; b[0] = 1'b0; uns = 0; pos = 1;
        for (int i = 0; i < cfg_n[d]; i++) begin
            b[pos] = v[i];
            uns += int'(v[i]);
            pos++;
        end
        if (cfg_p[d] == 1) begin
            b[pos] = (uns % 2 == 0);
            pos++;
        end else if (cfg_p[d] == 2) begin
            b[pos] = (uns % 2 == 1);
            pos++;
        end
        len = pos + cfg_s[d];
        return b;
    endfunction

    task automatic aceita(input int d, input logic [7:0] v, input logic [15:0] bits, input int len, input bit empilha);
        int n = 0;
        while (pronto[d] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pronto_antes", pronto[d], 1);
        dados      = v;
        partida[d] = 1'b1;
        if (empilha) fila.push_back('{d, bits, len});
        @(negedge clk);
        partida[d] = 1'b0;
    endtask

    task automatic recebe(input int d);
        quadro_t     q;
        logic [15:0] obs, mask;
        int          n, inst;
        n = 0;
        while (linha[d] !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("latencia_start", n, 0);
        if (fila.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard: actual=empty queue required=pending frame");
            return;
        end
        q = fila.pop_front();
        check("estado_tx", est_all[2*d +: 2], 1);
        obs  = '0;
        inst = 0;
        for (int i = 0; i < q.len; i++) begin
            obs[i] = linha[d];
            for (int c = 0; c < D; c++) begin
                if (linha[d] !== obs[i]) inst++;
                @(negedge clk);
            end
        end
        mask = 16'((32'd1 << q.len) - 1);
        check("quadro", obs, q.bits & mask);
        check("bit_estavel", inst, 0);
        check("fim_pulso", fim[d], 1);
        check("pronto_em_final", pronto[d], 0);
        check("linha_final", linha[d], 1);
        check("estado_final", est_all[2*d +: 2], 2);
        @(negedge clk);
        check("fim_apos", fim[d], 0);
        check("pronto_apos", pronto[d], 1);
        check("linha_repouso", linha[d], 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] b;
        int          len, f0, alta;

        tab[0] = '{0, 8'h55, 16'h06AA, 11};
        tab[1] = '{1, 8'h41, 16'h0382, 10};
        tab[2] = '{2, 8'h07, 16'h060E, 11};
        tab[3] = '{2, 8'h03, 16'h0406, 11};
        tab[4] = '{0, 8'h00, 16'h0600, 11};
        tab[5] = '{0, 8'hFF, 16'h07FE, 11};
        tab[6] = '{1, 8'h7F, 16'h03FE, 10};
        tab[7] = '{2, 8'hA5, 16'h054A, 11};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_linha", linha[d], 1);
            check("reset_pronto", pronto[d], 1);
            check("reset_fim", fim[d], 0);
            check("reset_estado", est_all[2*d +: 2], 0);
            check("reset_bit", bit_all[4*d +: 4], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            aceita(tab[i].dut, tab[i].dados, tab[i].bits, tab[i].len, 1'b1);
            recebe(tab[i].dut);
        end

        // Request and data changes during a frame must not affect it
        f0 = n_fim[2];
        b  = modelo(2, 8'hA5, len);
        aceita(2, 8'hA5, b, len, 1'b1);
        fork
            begin
                repeat (9) @(negedge clk);
                dados      = 8'h3C;
                partida[2] = 1'b1;
                @(negedge clk);
                partida[2] = 1'b0;
            end
        join_none
        recebe(2);
        alta = 0;
        repeat (30) begin
            @(negedge clk);
            if (linha[2] !== 1'b1 || pronto[2] !== 1'b1) alta++;
        end
        check("sem_quadro_extra", alta, 0);
        check("um_fim", n_fim[2] - f0, 1);

        // Reset during data bit 3 aborts silently
        f0 = n_fim[0];
        aceita(0, 8'h55, 16'h0, 0, 1'b0);
        repeat (4*D + 1) @(negedge clk);
        check("bit_antes_reset", bit_all[3:0], 4);
        check("linha_bit3", linha[0], 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_linha", linha[0], 1);
        check("abort_pronto", pronto[0], 1);
        check("abort_estado", est_all[1:0], 0);
        check("abort_bit", bit_all[3:0], 0);
        check("abort_fim", fim[0], 0);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("fim_abortado", n_fim[0] - f0, 0);
        b = modelo(0, 8'h5A, len);
        aceita(0, 8'h5A, b, len, 1'b1);
        recebe(0);

        // Back-to-back with partida held: two idle-high cycles between frames
        f0 = n_fim[0];
        b  = modelo(0, 8'h55, len);
        dados      = 8'h55;
        partida[0] = 1'b1;
        fila.push_back('{0, b, len});
        @(negedge clk);
        recebe(0);
        b     = modelo(0, 8'hAA, len);
        dados = 8'hAA;
        fila.push_back('{0, b, len});
        @(negedge clk);
        partida[0] = 1'b0;
        recebe(0);
        repeat (2) @(negedge clk);
        check("dois_fim", n_fim[0] - f0, 2);
        check("fila_vazia", fila.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
